hazard_scoreboard: RTL and testbench

//  Parametrised successor of the fixed 4-stage hazard unit. Tracks in-flight register writes in a shadow

---
 rtl/hazard_scoreboard_pkg.sv | 13 +
 rtl/hazard_scoreboard_operand_match.sv | 52 +++++
 rtl/hazard_scoreboard.sv | 112 +++++++++++
 tb/tb_hazard_scoreboard.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the hazard scoreboard: the forward-select code for the
// register file and the formula for the stage-select width.
package hazard_scoreboard_pkg;

  // Forward select meaning "take the operand from the register file"
  localparam int FWD_RF = 0;

  // Width needed to encode stage numbers 0..stages
  function automatic int sel_width(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_operand_match.sv
// Youngest-match lookup of one source operand across the in-flight slot vector.
// Slot k (1-based) sits at index k-1 of the packed vectors. The smallest k that
// matches decides the result; older matches are ignored.
module hazard_scoreboard_operand_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW   = 3,
  parameter int STAGES   = 3,
  parameter int ZERO_REG = 1,
  localparam int SW      = sel_width(STAGES)
) (
  input  logic [STAGES-1:0]        slot_valid,
  input  logic [STAGES*REG_AW-1:0] slot_dest,
  input  logic [STAGES*SW-1:0]     slot_rdy,
  input  logic [REG_AW-1:0]        src,
  input  logic                     rd,
  output logic                     hazard,
  output logic [SW-1:0]            forw_sel
);

  logic             src_live;
  logic [STAGES-1:0] hit;

  // A constant zero register never creates a dependency
  assign src_live = rd & ~((ZERO_REG != 0) && (src == '0));

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_hit
      assign hit[gi] = src_live & slot_valid[gi] &
                       (slot_dest[gi*REG_AW +: REG_AW] == src);
    end
  endgenerate

  // Scan oldest to youngest so the youngest hit is the last one written
  always_comb begin
    hazard   = 1'b0;
    forw_sel = SW'(FWD_RF);
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (hit[k]) begin
        if (SW'(k + 1) >= slot_rdy[k*SW +: SW]) begin
          hazard   = 1'b0;
          forw_sel = SW'(k + 1);
        end else begin
          hazard   = 1'b1;
          forw_sel = SW'(FWD_RF);
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-side hazard scoreboard: a shadow pipe of in-flight register writes
// that drives per-operand forward selects, a decode stall and a saturating
// stall counter.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW   = 3,
  parameter int STAGES   = 3,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 16,
  localparam int SW      = sel_width(STAGES)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              In_valid,
  input  logic [REG_AW-1:0] Src_a,
  input  logic [REG_AW-1:0] Src_b,
  input  logic              Rd_a,
  input  logic              Rd_b,
  input  logic [REG_AW-1:0] Dest,
  input  logic              We,
  input  logic [SW-1:0]     Rdy_stage,
  input  logic              Flush,
  input  logic              Cnt_clr,
  output logic              Stall,
  output logic [SW-1:0]     Forw_a_ctrl,
  output logic [SW-1:0]     Forw_b_ctrl,
  output logic [STAGES-1:0] Slot_valid,
  output logic [CNT_W-1:0]  Stall_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Slot k lives at index k-1 (valid) or field k-1 (dest, rdy)
  logic [STAGES-1:0]        valid_reg;
  logic [STAGES*REG_AW-1:0] dest_reg;
  logic [STAGES*SW-1:0]     rdy_reg;
  logic [CNT_W-1:0]         count_reg;

  logic [SW-1:0]     rdy_norm;
  logic              slot1_load;
  logic [REG_AW-1:0] src_sel  [2];
  logic              rd_sel   [2];
  logic              haz      [2];
  logic [SW-1:0]     fwd_sel  [2];

  // Out-of-range ready stages are treated as the worst case (write-back)
  always_comb begin
    rdy_norm = Rdy_stage;
    if (Rdy_stage == '0 || 32'(Rdy_stage) > STAGES) begin
      rdy_norm = SW'(STAGES);
    end
  end

  assign src_sel[0] = Src_a;
  assign src_sel[1] = Src_b;
  assign rd_sel[0]  = Rd_a;
  assign rd_sel[1]  = Rd_b;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      hazard_scoreboard_operand_match #(
        .REG_AW   (REG_AW),
        .STAGES   (STAGES),
        .ZERO_REG (ZERO_REG)
      ) u_match (
        .slot_valid (valid_reg),
        .slot_dest  (dest_reg),
        .slot_rdy   (rdy_reg),
        .src        (src_sel[gi]),
        .rd         (rd_sel[gi]),
        .hazard     (haz[gi]),
        .forw_sel   (fwd_sel[gi])
      );
    end
  endgenerate

  assign Stall       = In_valid & (haz[0] | haz[1]);
  assign Forw_a_ctrl = fwd_sel[0];
  assign Forw_b_ctrl = fwd_sel[1];
  assign Slot_valid  = valid_reg;
  assign Stall_count = count_reg;

  // Only a writing instruction that actually leaves decode occupies slot 1
  assign slot1_load = In_valid & We & ~Stall & ~Flush;

  // Shadow pipe: every slot advances each cycle, slot STAGES retires
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      valid_reg <= '0;
      dest_reg  <= '0;
      rdy_reg   <= '0;
    end else begin
      valid_reg <= {valid_reg[STAGES-2:0], slot1_load};
      dest_reg  <= {dest_reg[(STAGES-1)*REG_AW-1:0], Dest};
      rdy_reg   <= {rdy_reg[(STAGES-1)*SW-1:0], rdy_norm};
    end
  end

  // Stall cycles counted unless flushed; clear beats increment; saturates
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      count_reg <= '0;
    end else if (Cnt_clr) begin
      count_reg <= '0;
    end else if (Stall && !Flush && count_reg != CNT_MAX) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized and directed bench for hazard_scoreboard against a list-of-
// in-flight-writes reference model (STAGES=3, REG_AW=3, narrow counter).
module tb_hazard_scoreboard;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] src_a, src_b, dest;
  logic       rd_a, rd_b, we;
  logic [1:0] rdy_stage;
  logic       flush, cnt_clr;
  logic       stall;
  logic [1:0] forw_a, forw_b;
  logic [2:0] slot_valid;
  logic [CNT_W-1:0] stall_count;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .REG_AW (3), .STAGES (3), .ZERO_REG (1), .CNT_W (CNT_W)
  ) dut (
    .Clk (clk), .Rst (rst), .In_valid (in_valid),
    .Src_a (src_a), .Src_b (src_b), .Rd_a (rd_a), .Rd_b (rd_b),
    .Dest (dest), .We (we), .Rdy_stage (rdy_stage),
    .Flush (flush), .Cnt_clr (cnt_clr),
    .Stall (stall), .Forw_a_ctrl (forw_a), .Forw_b_ctrl (forw_b),
    .Slot_valid (slot_valid), .Stall_count (stall_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: in-flight writes indexed by pipeline position 1..3
  bit m_valid [1:3];
  int m_dest  [1:3];
  int m_rdy   [1:3];
  int m_cnt;

  // Outputs observed in the most recent step (for directed checks)
  logic       obs_stall;
  logic [1:0] obs_fa, obs_fb;
  logic [2:0] obs_sv;
  logic [CNT_W-1:0] obs_cnt;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Youngest in-flight write to src decides; ready at its position or not
  function automatic void model_operand(input int src, input bit rd, output int fsel, output bit haz);
    fsel = 0;
    haz  = 1'b0;
    if (!rd || src == 0) return;
    for (int k = 1; k <= 3; k++) begin
      if (m_valid[k] && m_dest[k] == src) begin
        if (k >= m_rdy[k]) fsel = k;
        else haz = 1'b1;
        return;
      end
    end
  endfunction

  task automatic idle_inputs();
    rst = 1'b1; in_valid = 1'b0; src_a = '0; src_b = '0; rd_a = 1'b0; rd_b = 1'b0;
    dest = '0; we = 1'b0; rdy_stage = 2'd1; flush = 1'b0; cnt_clr = 1'b0;
  endtask

  // One cycle: compare outputs at the falling edge, then advance the model
  task automatic step(input string tag);
    int  fa, fb, sv;
    bit  ha, hb, exp_stall;
    int  r;
    @(negedge clk);
    model_operand(int'(src_a), rd_a, fa, ha);
    model_operand(int'(src_b), rd_b, fb, hb);
    exp_stall = in_valid & (ha | hb);
    sv = (m_valid[3] << 2) | (m_valid[2] << 1) | int'(m_valid[1]);
    obs_stall = stall; obs_fa = forw_a; obs_fb = forw_b; obs_sv = slot_valid; obs_cnt = stall_count;
    check_val({tag, "_stall"}, 32'(stall), 32'(exp_stall));
    check_val({tag, "_fwd_a"}, 32'(forw_a), 32'(fa));
    check_val({tag, "_fwd_b"}, 32'(forw_b), 32'(fb));
    check_val({tag, "_slots"}, 32'(slot_valid), 32'(sv));
    check_val({tag, "_count"}, 32'(stall_count), 32'(m_cnt));
    @(posedge clk);
    if (!rst) begin
      for (int k = 1; k <= 3; k++) m_valid[k] = 1'b0;
      m_cnt = 0;
    end else begin
      for (int k = 3; k >= 2; k--) begin
        m_valid[k] = m_valid[k-1]; m_dest[k] = m_dest[k-1]; m_rdy[k] = m_rdy[k-1];
      end
      r = int'(rdy_stage);
      m_valid[1] = in_valid & we & !exp_stall & !flush;
      m_dest[1]  = int'(dest);
      m_rdy[1]   = (r == 0 || r > 3) ? 3 : r;
      if (cnt_clr) m_cnt = 0;
      else if (exp_stall && !flush && m_cnt < CMAX) m_cnt++;
    end
    #1;
  endtask

  task automatic issue(input int d, input int rdy, input string tag);
    idle_inputs();
    in_valid = 1'b1; dest = 3'(d); we = 1'b1; rdy_stage = 2'(rdy);
    step(tag);
  endtask

  initial begin
    for (int k = 1; k <= 3; k++) begin m_valid[k] = 1'b0; m_dest[k] = 0; m_rdy[k] = 3; end
    m_cnt = 0;
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 1: fill all slots, then reset for two edges
    issue(1, 1, "t1_fill0"); issue(2, 1, "t1_fill1"); issue(3, 1, "t1_fill2");
    idle_inputs(); rst = 1'b0; step("t1_rst0");
    idle_inputs(); rst = 1'b0; step("t1_rst1");
    idle_inputs(); in_valid = 1'b1; src_a = 3'd1; src_b = 3'd2; rd_a = 1'b1; rd_b = 1'b1;
    step("t1_after");
    check_val("t1_sv", 32'(obs_sv), 32'd0);
    check_val("t1_cnt", 32'(obs_cnt), 32'd0);

    // 2: ALU result forwarded from stage 1
    issue(2, 1, "t2_issue");
    idle_inputs(); in_valid = 1'b1; src_a = 3'd2; rd_a = 1'b1; step("t2_use");
    check_val("t2_fa", 32'(obs_fa), 32'd1);
    check_val("t2_stall", 32'(obs_stall), 32'd0);

    // 3: load-use stalls once, then forwards from stage 2
    issue(3, 2, "t3_issue");
    idle_inputs(); in_valid = 1'b1; src_b = 3'd3; rd_b = 1'b1; step("t3_stall");
    check_val("t3_stall", 32'(obs_stall), 32'd1);
    step("t3_fwd");
    check_val("t3_fb", 32'(obs_fb), 32'd2);
    check_val("t3_cnt", 32'(obs_cnt), 32'd1);

    // 4: youngest of two matches wins, then drains
    issue(4, 1, "t4_old");
    idle_inputs(); step("t4_gap");
    issue(4, 1, "t4_young");
    idle_inputs(); in_valid = 1'b1; src_a = 3'd4; rd_a = 1'b1; step("t4_use");
    check_val("t4_fa_young", 32'(obs_fa), 32'd1);
    idle_inputs(); repeat (3) step("t4_idle");
    idle_inputs(); in_valid = 1'b1; src_a = 3'd4; rd_a = 1'b1; step("t4_drained");
    check_val("t4_fa_drained", 32'(obs_fa), 32'd0);

    // 5: register 0 never forwards; unread operand never stalls
    issue(0, 1, "t5_r0");
    idle_inputs(); in_valid = 1'b1; src_a = 3'd0; rd_a = 1'b1; step("t5_use_r0");
    check_val("t5_fa_r0", 32'(obs_fa), 32'd0);
    issue(5, 2, "t5_load");
    idle_inputs(); in_valid = 1'b1; src_b = 3'd5; rd_b = 1'b0; step("t5_noread");
    check_val("t5_stall_noread", 32'(obs_stall), 32'd0);

    // 6: flush during a load-use stall is not counted and bubbles slot 1
    issue(6, 2, "t6_load");
    idle_inputs(); in_valid = 1'b1; src_b = 3'd6; rd_b = 1'b1; we = 1'b1; dest = 3'd7; flush = 1'b1;
    step("t6_flush");
    check_val("t6_stall_shown", 32'(obs_stall), 32'd1);
    idle_inputs(); step("t6_after");
    check_val("t6_cnt", 32'(obs_cnt), 32'd1);
    check_val("t6_slot1", 32'(obs_sv[0]), 32'd0);

    // 6b: counter saturation, then clear with priority over a stall
    for (int i = 0; i < 10; i++) begin
      issue(7, 3, "t6_sat_issue");
      idle_inputs(); in_valid = 1'b1; src_a = 3'd7; rd_a = 1'b1;
      step("t6_sat_s1"); step("t6_sat_s2");
    end
    idle_inputs(); step("t6_sat_hold");
    check_val("t6_sat", 32'(obs_cnt), CMAX);
    issue(7, 3, "t6_clr_issue");
    idle_inputs(); in_valid = 1'b1; src_a = 3'd7; rd_a = 1'b1; cnt_clr = 1'b1; step("t6_clr");
    idle_inputs(); step("t6_clr_after");
    check_val("t6_cleared", 32'(obs_cnt), 32'd0);

    // Random traffic with small register set to provoke hazards
    for (int i = 0; i < 400; i++) begin
      idle_inputs();
      rst       = ($urandom_range(0, 63) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      src_a     = 3'($urandom_range(0, 3));
      src_b     = 3'($urandom_range(0, 3));
      rd_a      = $urandom_range(0, 1) == 1;
      rd_b      = $urandom_range(0, 1) == 1;
      dest      = 3'($urandom_range(0, 3));
      we        = ($urandom_range(0, 3) != 0);
      rdy_stage = 2'($urandom_range(0, 3));
      flush     = ($urandom_range(0, 9) == 0);
      cnt_clr   = ($urandom_range(0, 31) == 0);
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
